// File: rtl/data_io_upload_if.sv
// data_io_upload_if: IO-controller SPI pins plus the RAM read-request/acknowledge port.
interface data_io_upload_if #(parameter int ADDR_W = 25);
  logic sck, ss, sdi, sdo, rd, rd_ack;
  logic [ADDR_W-1:0] a;
  logic [7:0] q;
  modport master (output sck, ss, sdi, q, rd_ack, input sdo, rd, a);
  modport slave (input sck, ss, sdi, q, rd_ack, output sdo, rd, a);
endinterface

// File: rtl/data_io_upload.sv
// data_io_upload: SPI-slave streamer of RAM bytes to the IO controller via a 1-byte prefetch.
// Optional UPLOAD_CHECKSUM_EN adds a running byte checksum returned by CMD_RX_SUM.
module data_io_upload #(
  parameter int ADDR_W = 25,
  parameter logic [7:0] CMD_RX = 8'h56,
  parameter logic [7:0] CMD_RX_DAT = 8'h57,
  parameter logic [7:0] CMD_RX_SUM = 8'h58
) (
  input  logic              clk,
  input  logic              reset,
  data_io_upload_if.slave   bus,
  input  logic [ADDR_W-1:0] upload_base,
  input  logic [ADDR_W-1:0] upload_len,
  output logic              uploading,
  output logic [ADDR_W-1:0] sent
);
  localparam logic [0:0] IDLE = 1'b0, REQ = 1'b1;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  logic [2:0] sck_s;
  logic [1:0] ss_s, sdi_s;
  logic [3:0] cnt;
  logic [6:0] sbuf;
  logic [7:0] cmd, shreg, pf_data, cur_data, sum_val, ld_cmd, ld_val, byte_in;
  logic [ADDR_W-1:0] ptr, remain;
  logic pf_valid, cur_valid, replay, state;
  logic rise, fall, act, ld, ld_dat, take, param, start, stop;
  always_comb begin
    rise = sck_s[1] & ~sck_s[2];
    fall = ~sck_s[1] & sck_s[2];
    byte_in = {sbuf, sdi_s[1]};
    act = rise & ~ss_s[1];
    ld_cmd = cnt == 4'd7 ? byte_in : cmd;
    ld = act && cnt[2:0] == 3'd7;
    ld_dat = ld && ld_cmd == CMD_RX_DAT;
    take = ld_dat && !replay && pf_valid;
    param = act && cnt == 4'd15 && cmd == CMD_RX;
    start = param && byte_in[0];
    stop = param && !byte_in[0];
    ld_val = ld_dat ? (replay ? cur_data : pf_valid ? pf_data : 8'h00)
           : ld_cmd == CMD_RX_SUM ? sum_val : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s <= '0;
      ss_s <= '0;
      sdi_s <= '0;
      cnt <= '0;
      sbuf <= '0;
      cmd <= '0;
      shreg <= '0;
      bus.sdo <= 1'b0;
      pf_data <= '0;
      pf_valid <= 1'b0;
      cur_data <= '0;
      cur_valid <= 1'b0;
      replay <= 1'b0;
      state <= IDLE;
      bus.rd <= 1'b0;
      bus.a <= '0;
      ptr <= '0;
      remain <= '0;
      uploading <= 1'b0;
      sent <= '0;
    end else begin
      sck_s <= {sck_s[1:0], bus.sck};
      ss_s <= {ss_s[0], bus.ss};
      sdi_s <= {sdi_s[0], bus.sdi};
      // a deselect while a data byte is in flight replays that byte on the next slot
      if (ss_s[1]) begin
        cnt <= '0;
        bus.sdo <= 1'b0;
        shreg <= '0;
        if (cnt[3] && cmd == CMD_RX_DAT) replay <= cur_valid;
      end else if (rise) begin
        sbuf <= byte_in[6:0];
        cnt <= cnt == 4'd15 ? 4'd8 : cnt + 4'd1;
        if (cnt == 4'd7) cmd <= byte_in;
        if (ld) begin
          shreg <= ld_val;
          bus.sdo <= ld_val[7];
        end
      end else if (fall && cnt != 4'd8) begin
        bus.sdo <= shreg[6];
        shreg <= {shreg[6:0], 1'b0};
      end
      if (ld_dat) begin
        replay <= 1'b0;
        if (!replay) begin
          pf_valid <= 1'b0;
          cur_data <= pf_data;
          cur_valid <= pf_valid;
        end
        if (take) sent <= sent + ONE;
      end
      if (state == IDLE) begin
        if (uploading && !pf_valid && remain != '0) begin
          bus.rd <= 1'b1;
          bus.a <= ptr;
          state <= REQ;
        end
      end else if (bus.rd_ack) begin
        pf_data <= bus.q;
        pf_valid <= 1'b1;
        ptr <= ptr + ONE;
        remain <= remain - ONE;
        bus.rd <= 1'b0;
        state <= IDLE;
      end
      if (start) begin
        ptr <= upload_base;
        remain <= upload_len;
        sent <= '0;
        uploading <= 1'b1;
        pf_valid <= 1'b0;
        cur_valid <= 1'b0;
        replay <= 1'b0;
        bus.rd <= 1'b0;
        state <= IDLE;
      end
      if (stop) begin
        uploading <= 1'b0;
        bus.rd <= 1'b0;
        state <= IDLE;
      end
    end
  end
`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] checksum;
  always_ff @(posedge clk) begin
    if (reset || start) checksum <= '0;
    else if (take) checksum <= checksum + pf_data;
  end
  assign sum_val = checksum;
`else
  assign sum_val = 8'h00;
`endif
endmodule
